// File: rtl/morse_pkg.sv
// Shared constants for the Morse keyer: state codes, code-word field layout,
// unit multipliers and the element-count clamp.
package morse_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_MARK = 3'd1;
  localparam state_t S_GAP  = 3'd2;
  localparam state_t S_CGAP = 3'd3;
  localparam state_t S_WGAP = 3'd4;
  localparam state_t S_DONE = 3'd5;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 5;
  localparam int ELEM_MSB = 4;
  localparam int MAX_LEN  = 5;

  localparam logic [2:0] DOT_UNITS  = 3'd1;
  localparam logic [2:0] DASH_UNITS = 3'd3;
  localparam logic [2:0] GAP_UNITS  = 3'd1;
  localparam logic [2:0] CGAP_UNITS = 3'd3;
  localparam logic [2:0] WGAP_UNITS = 3'd4;

  typedef struct packed {
    logic [LEN_MSB-LEN_LSB:0] len;
    logic [ELEM_MSB:0]        elems;
  } code_t;

  // Lengths 6 and 7 cannot be encoded in five element bits, so treat them as 5.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/unit_timer.sv
// Loadable down-counter timing N Morse units; expire pulses for one cycle in
// the last cycle of the loaded period.
module unit_timer #(
  parameter int UNIT_CYCLES = 6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] units,
  output logic       expire
);

  localparam int W = $clog2(4 * UNIT_CYCLES);

  logic [W-1:0] count_reg;
  logic         run_reg;
  logic [W-1:0] load_val;

  assign load_val = W'(units) * W'(UNIT_CYCLES) - W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      run_reg   <= 1'b0;
    end else if (load) begin
      count_reg <= load_val;
      run_reg   <= 1'b1;
    end else if (run_reg) begin
      if (count_reg == '0) begin
        run_reg <= 1'b0;
      end else begin
        count_reg <= count_reg - W'(1);
      end
    end
  end

  // run_reg gates the pulse so an idle counter parked at zero stays quiet.
  assign expire = run_reg && (count_reg == '0);

endmodule

// File: rtl/morse_keyer.sv
// Paces one Morse code word per tx_rdy/tx_done handshake onto key_out.
// Optional sidetone output enabled by defining MORSE_KEYER_SIDETONE_EN.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 6000000
`ifdef MORSE_KEYER_SIDETONE_EN
  ,
  parameter int TONE_HALF_CYCLES = 50000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_in,
  input  logic       tx_rdy,
  output logic       tx_done,
  output logic       key_out,
  output logic       busy
`ifdef MORSE_KEYER_SIDETONE_EN
  ,
  output logic       tone_out
`endif
);

  state_t     state_reg, state_next;
  logic [4:0] shift_reg, shift_next;
  logic [2:0] elems_reg, elems_next;
  logic       key_next, done_next, busy_next;
  logic       load, expire;
  logic [2:0] units;
  code_t      cw;
  logic [2:0] len_in;

  assign cw     = code_t'(code_in);
  assign len_in = clamp_len(cw.len);

  unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .units  (units),
    .expire (expire)
  );

  // The timer is reloaded on the same edge the state changes, so phases abut
  // with no idle cycle between them.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    elems_next = elems_reg;
    key_next   = key_out;
    done_next  = 1'b0;
    busy_next  = busy;
    load       = 1'b0;
    units      = DOT_UNITS;
    case (state_reg)
      S_IDLE: begin
        if (tx_rdy) begin
          load       = 1'b1;
          shift_next = cw.elems;
          elems_next = len_in;
          busy_next  = 1'b1;
          if (len_in == 3'd0) begin
            state_next = S_WGAP;
            units      = WGAP_UNITS;
          end else begin
            state_next = S_MARK;
            key_next   = 1'b1;
            units      = cw.elems[ELEM_MSB] ? DASH_UNITS : DOT_UNITS;
          end
        end
      end
      S_MARK: begin
        if (expire) begin
          key_next   = 1'b0;
          elems_next = elems_reg - 3'd1;
          load       = 1'b1;
          if (elems_reg > 3'd1) begin
            state_next = S_GAP;
            units      = GAP_UNITS;
          end else begin
            state_next = S_CGAP;
            units      = CGAP_UNITS;
          end
        end
      end
      S_GAP: begin
        if (expire) begin
          shift_next = shift_reg << 1;
          key_next   = 1'b1;
          load       = 1'b1;
          state_next = S_MARK;
          units      = shift_reg[ELEM_MSB-1] ? DASH_UNITS : DOT_UNITS;
        end
      end
      S_CGAP, S_WGAP: begin
        if (expire) begin
          state_next = S_DONE;
          done_next  = 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next = S_IDLE;
        key_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      shift_reg <= '0;
      elems_reg <= '0;
      key_out   <= 1'b0;
      tx_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      elems_reg <= elems_next;
      key_out   <= key_next;
      tx_done   <= done_next;
      busy      <= busy_next;
    end
  end

`ifdef MORSE_KEYER_SIDETONE_EN
  localparam int TW = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;

  logic [TW-1:0] tone_cnt_reg;

  // Follows key_next so the tone drops on the same edge as the key line.
  always_ff @(posedge clk) begin
    if (rst || !key_next) begin
      tone_cnt_reg <= '0;
      tone_out     <= 1'b0;
    end else if (!key_out) begin
      tone_cnt_reg <= '0;
    end else if (tone_cnt_reg == TW'(TONE_HALF_CYCLES - 1)) begin
      tone_cnt_reg <= '0;
      tone_out     <= ~tone_out;
    end else begin
      tone_cnt_reg <= tone_cnt_reg + TW'(1);
    end
  end
`endif

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Paces Morse characters onto a key line with standard unit timing. It sits downstream of the Morse lookup table and consumes one 8-bit code word per character through the table's `tx_rdy`/`tx_done` handshake. It drives `key_out` for the LED or buzzer with ITU element and gap durations. The block is the only consumer of the table's output.

## Interface
- `UNIT_CYCLES`, 6000000, clock cycles per Morse unit; legal range ≥ 2.
- `TONE_HALF_CYCLES`, 50000, half-period in cycles of the sidetone square wave; used only with `MORSE_KEYER_SIDETONE_EN`.
- `clk`  in  1  system clock, the block's only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `code_in`  in  8  code word from the table; sampled only on acceptance.
- `tx_rdy`  in  1  code word valid; held high by the table until `tx_done` is seen.
- `tx_done`  out  1  one-cycle pulse when the character and its trailing gap have completed.
- `key_out`  out  1  key line; 1 = tone on.
- `busy`  out  1  high in every state except IDLE.
- `tone_out`  out  1  sidetone output; present only with `MORSE_KEYER_SIDETONE_EN`.

## Operation
- Code word format:
  - `[7:5]` holds the element count LEN.
  - `[4:0]` holds the elements, MSB-first from bit 4; 0 = dot, 1 = dash.
  - LEN 6 or 7 is clamped to 5.
  - LEN 0 means word space; bits `[4:0]` are ignored.
- State machine:
  - **IDLE**: if `tx_rdy` = 1, latch `code_in` and LEN into a shift register and element counter. Go to MARK, or to WGAP if LEN = 0.
  - **MARK**: `key_out` = 1 for 1 unit (dot) or 3 units (dash). Then decrement the element count. Go to GAP if elements remain, otherwise go to CGAP.
  - **GAP**: `key_out` = 0 for 1 unit, shift to the next element, then go to MARK.
  - **CGAP**: `key_out` = 0 for 3 units (inter-character gap), then go to DONE.
  - **WGAP**: `key_out` = 0 for 4 units, then go to DONE. Together with the preceding character's 3-unit CGAP this gives the 7-unit word gap.
  - **DONE**: `tx_done` = 1 for exactly one cycle, then go to IDLE.
- `tx_rdy` is ignored outside IDLE.
- The table drops `tx_rdy` the cycle after `tx_done`, so IDLE never re-accepts the same word.

## Timing
- All outputs are registered.
- Reset values: `key_out` = 0, `tx_done` = 0, `busy` = 0, `tone_out` = 0; state = IDLE; counters = 0.
- Acceptance latency:
  - `tx_rdy` sampled high in IDLE at edge k.
  - `key_out`, or the WGAP low period, and `busy` begin in cycle k+1.
- Durations are exact:
  - 1 unit = `UNIT_CYCLES` cycles.
  - Dash = 3×, CGAP = 3×, WGAP = 4× `UNIT_CYCLES` cycles.
  - No extra cycles at state boundaries.
- `tx_done` is asserted in the cycle immediately after the last gap cycle. IDLE follows in the next cycle.
- Unit counter width is `$clog2(4*UNIT_CYCLES)`. It loads a terminal count of N×`UNIT_CYCLES`−1 and counts down; a phase ends when the counter reaches 0.
- Reset mid-character:
  - The character is abandoned and no `tx_done` is issued.
  - `key_out` is low in the cycle after the `rst` edge.
- `rst` has priority over acceptance in the same cycle.

## Configuration
- `MORSE_KEYER_SIDETONE_EN` defined:
  - A free-running toggle counter generates `tone_out`, a square wave with half-period `TONE_HALF_CYCLES`, gated by `key_out`.
  - `tone_out` is 0 whenever `key_out` = 0.
  - The toggle counter resets when `key_out` falls, so every tone burst starts low.
- Undefined: the `tone_out` port and its counter are absent; all other behaviour is identical.

## Structure
- Package `morse_pkg`:
  - state enum (IDLE, MARK, GAP, CGAP, WGAP, DONE);
  - code-word field constants (LEN_MSB = 7, LEN_LSB = 5, ELEM_MSB = 4, MAX_LEN = 5);
  - unit multipliers (DOT = 1, DASH = 3, CGAP = 3, WGAP = 4).
- Sub-module `unit_timer`:
  - loadable down-counter; inputs `load` and `units[2:0]`;
  - output `expire`, a one-cycle pulse;
  - parameterised by `UNIT_CYCLES`.

## Test plan
All scenarios use `UNIT_CYCLES` = 4. Cycle numbers are counted from the acceptance edge 0.
- 'E', 0x20: `key_out` high in cycles 1–4, low in 5–16; `tx_done` pulses in cycle 17 only; `busy` low from cycle 18.
- 'A', 0x48: high 1–4, low 5–8, high 9–20, low 21–32; `tx_done` in cycle 33.
- Space, 0x00: `key_out` stays low; `busy` high in 1–17; `tx_done` in cycle 17.
- LEN clamp, 0xFF: five dashes with 1-unit gaps; `tx_done` in cycle 1+5·12+4·4+12 = 89.
- `rst` pulsed in cycle 10 of 'A': `key_out` = 0, `busy` = 0 and no `tx_done` from cycle 11. A new word presented afterwards is accepted normally.
- Back-to-back words driven by a table model: each word is accepted exactly once, with no dropped or duplicated characters. With sidetone enabled, `tone_out` toggles every `TONE_HALF_CYCLES` only while `key_out` = 1.
